// File: rtl/ysyx_bus_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owners and AXI response codes.
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

endpackage

// File: rtl/ysyx_arb_rr2.sv
// Two-way round-robin picker: bit 0 is the IFU, bit 1 the LSU; 'last' names the previous winner.
module ysyx_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       onehot
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  assign onehot = (gnt == 2'b01) || (gnt == 2'b10);

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Two-master memory arbiter: IFU reads and LSU reads/writes share one AXI-Lite master port,
// one transaction at a time, turned into level-request / one-cycle-response handshakes.
module ysyx_mem_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_awvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  output logic                lsu_bvalid,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  state_e              state, state_nxt;
  logic                owner, last_grant, wr, err;
  logic                aw_done, w_done;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [31:0]         cnt;
  logic [1:0]          gnt;
  logic                gnt_ok, timed_out, aw_ok, w_ok;

  ysyx_arb_rr2 u_rr (
    .req    ({lsu_arvalid | lsu_awvalid, ifu_arvalid}),
    .last   (last_grant),
    .gnt    (gnt),
    .onehot (gnt_ok)
  );

  // cnt counts cycles already spent waiting, so the response lands TIMEOUT cycles after entry
  assign timed_out = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT - 1));
  assign aw_ok     = aw_done | m_awready;
  assign w_ok      = w_done | m_wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_ok) state_nxt = (gnt[1] && lsu_awvalid) ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (m_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_rvalid || timed_out) state_nxt = RESP;
      WR_ADDR: if (aw_ok && w_ok) state_nxt = WR_RESP;
      WR_RESP: if (m_bvalid || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      wr         <= 1'b0;
      err        <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      cnt <= ((state == RD_DATA) || (state == WR_RESP)) ? cnt + 32'd1 : 32'd0;
      case (state)
        IDLE: if (gnt_ok) begin
          owner      <= gnt[1];
          last_grant <= gnt[1];
          wr         <= gnt[1] & lsu_awvalid;
          addr_q     <= !gnt[1] ? ifu_araddr : (lsu_awvalid ? lsu_awaddr : lsu_araddr);
          wdata_q    <= lsu_wdata;
          wstrb_q    <= lsu_wstrb;
          aw_done    <= 1'b0;
          w_done     <= 1'b0;
          err        <= 1'b0;
        end
        RD_DATA: begin
          if (m_rvalid) begin
            rdata_q <= m_rdata;
            err     <= (m_rresp != OKAY);
          end else if (timed_out) begin
            rdata_q <= '0;
            err     <= 1'b1;
          end
        end
        WR_ADDR: begin
          if (m_awready) aw_done <= 1'b1;
          if (m_wready)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (m_bvalid)       err <= (m_bresp != OKAY);
          else if (timed_out) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of state plus registered latches, never of live inputs
  always_comb begin
    m_araddr   = addr_q;
    m_awaddr   = addr_q;
    m_wdata    = wdata_q;
    m_wstrb    = wstrb_q;
    m_arvalid  = (state == RD_ADDR);
    m_rready   = (state == RD_DATA);
    m_awvalid  = (state == WR_ADDR) && !aw_done;
    m_wvalid   = (state == WR_ADDR) && !w_done;
    m_bready   = (state == WR_RESP);
    ifu_rvalid = (state == RESP) && (owner == OWN_IFU) && !wr;
    lsu_rvalid = (state == RESP) && (owner == OWN_LSU) && !wr;
    lsu_bvalid = (state == RESP) && wr;
    bus_err    = (state == RESP) && err;
    ifu_rdata  = rdata_q;
    lsu_rdata  = rdata_q;
  end

endmodule
